axis_pkt_fifo: RTL and testbench

- Parametrised AXI-Stream FIFO between an upstream stream master (s_ side) and a downstream slave (m_ side), single clock domain.
- Buffers full AXI-Stream beats: tdata, tstrb, tkeep, tlast and tuser.
- Optional packet (store-and-forward) mode releases a packet only after its tlast beat is stored.
- Gives the stream datapath elasticity and frame-level decoupling; exports fill status for flow-control logic.

---
 rtl/axis_pkt_fifo.sv | 117 +++++++++++
 tb/tb_axis_pkt_fifo.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream beat FIFO with optional store-and-forward packet gating.
// Single clock; the head entry drives the m_ payload combinationally.
module axis_pkt_fifo #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned USER_SIZE = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PKT_MODE  = 0
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [DATA_SIZE-1:0]     s_tdata,
  input  logic [DATA_SIZE/8-1:0]   s_tstrb,
  input  logic [DATA_SIZE/8-1:0]   s_tkeep,
  input  logic                     s_tlast,
  input  logic [USER_SIZE-1:0]     s_tuser,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DATA_SIZE-1:0]     m_tdata,
  output logic [DATA_SIZE/8-1:0]   m_tstrb,
  output logic [DATA_SIZE/8-1:0]   m_tkeep,
  output logic                     m_tlast,
  output logic [USER_SIZE-1:0]     m_tuser,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned KW  = DATA_SIZE / 8;
  localparam int unsigned EW  = DATA_SIZE + 2 * KW + 1 + USER_SIZE;
  localparam bit          PKT = (PKT_MODE != 32'd0);

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;

  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] pkt_cnt, pkt_cnt_nxt;
  logic          flush, flush_nxt;
  logic          ready_q, ready_nxt;
  logic          wr_en, rd_en;
  logic          full_nxt;

  // Status derived from the wrap-bit pointers.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign fill_level = wr_ptr - rd_ptr;

  // Store-and-forward holds the head back until a whole packet is stored or a flush is forced.
  assign m_tvalid = !empty && (!PKT || (pkt_cnt != '0) || flush);
  assign s_tready = ready_q;

  assign wr_en = s_tvalid && ready_q;
  assign rd_en = m_tvalid && m_tready;

  // Head entry unpacked as {tdata, tstrb, tkeep, tlast, tuser}.
  assign head    = mem[rd_ptr[AW-1:0]];
  assign m_tuser = head[USER_SIZE-1:0];
  assign m_tlast = head[USER_SIZE];
  assign m_tkeep = head[USER_SIZE+1 +: KW];
  assign m_tstrb = head[USER_SIZE+1+KW +: KW];
  assign m_tdata = head[USER_SIZE+1+2*KW +: DATA_SIZE];

  // Payload storage; intentionally not reset.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tuser};
    end
  end

  // Next-state for pointers, ready, packet count and flush.
  always_comb begin
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    pkt_cnt_nxt = pkt_cnt;
    flush_nxt   = flush;

    if (wr_en) wr_ptr_nxt = wr_ptr + PW'(1);
    if (rd_en) rd_ptr_nxt = rd_ptr + PW'(1);

    full_nxt  = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
    ready_nxt = !full_nxt;

    if (PKT) begin
      unique case ({wr_en && s_tlast, rd_en && m_tlast})
        2'b10:   pkt_cnt_nxt = pkt_cnt + PW'(1);
        2'b01:   pkt_cnt_nxt = pkt_cnt - PW'(1);
        default: pkt_cnt_nxt = pkt_cnt;
      endcase
      // A packet longer than the FIFO would never complete; fall back to cut-through.
      if (rd_en && m_tlast)         flush_nxt = 1'b0;
      if (full && (pkt_cnt == '0))  flush_nxt = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
      flush   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      pkt_cnt <= pkt_cnt_nxt;
      flush   <= flush_nxt;
      ready_q <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed and randomised checks of axis_pkt_fifo in cut-through and store-and-forward builds.
`timescale 1ns/1ps
module tb_axis_pkt_fifo;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Cut-through, DEPTH 16
  logic        c_svalid, c_sready, c_slast, c_mvalid, c_mready, c_mlast, c_full, c_empty;
  logic [31:0] c_sdata, c_suser, c_mdata, c_muser;
  logic [3:0]  c_sstrb, c_skeep, c_mstrb, c_mkeep;
  logic [4:0]  c_fill;
  // Store-and-forward, DEPTH 16
  logic        p_svalid, p_sready, p_slast, p_mvalid, p_mready, p_mlast, p_full, p_empty;
  logic [31:0] p_sdata, p_suser, p_mdata, p_muser;
  logic [3:0]  p_sstrb, p_skeep, p_mstrb, p_mkeep;
  logic [4:0]  p_fill;
  // Store-and-forward, DEPTH 8
  logic        q_svalid, q_sready, q_slast, q_mvalid, q_mready, q_mlast, q_full, q_empty;
  logic [31:0] q_sdata, q_suser, q_mdata, q_muser;
  logic [3:0]  q_sstrb, q_skeep, q_mstrb, q_mkeep;
  logic [3:0]  q_fill;

  axis_pkt_fifo #(.DATA_SIZE(32), .USER_SIZE(32), .DEPTH(16), .PKT_MODE(0)) u_c (
    .aclk(clk), .areset(areset),
    .s_tvalid(c_svalid), .s_tready(c_sready), .s_tdata(c_sdata), .s_tstrb(c_sstrb),
    .s_tkeep(c_skeep), .s_tlast(c_slast), .s_tuser(c_suser),
    .m_tvalid(c_mvalid), .m_tready(c_mready), .m_tdata(c_mdata), .m_tstrb(c_mstrb),
    .m_tkeep(c_mkeep), .m_tlast(c_mlast), .m_tuser(c_muser),
    .fill_level(c_fill), .full(c_full), .empty(c_empty));

  axis_pkt_fifo #(.DATA_SIZE(32), .USER_SIZE(32), .DEPTH(16), .PKT_MODE(1)) u_p (
    .aclk(clk), .areset(areset),
    .s_tvalid(p_svalid), .s_tready(p_sready), .s_tdata(p_sdata), .s_tstrb(p_sstrb),
    .s_tkeep(p_skeep), .s_tlast(p_slast), .s_tuser(p_suser),
    .m_tvalid(p_mvalid), .m_tready(p_mready), .m_tdata(p_mdata), .m_tstrb(p_mstrb),
    .m_tkeep(p_mkeep), .m_tlast(p_mlast), .m_tuser(p_muser),
    .fill_level(p_fill), .full(p_full), .empty(p_empty));

  axis_pkt_fifo #(.DATA_SIZE(32), .USER_SIZE(32), .DEPTH(8), .PKT_MODE(1)) u_q (
    .aclk(clk), .areset(areset),
    .s_tvalid(q_svalid), .s_tready(q_sready), .s_tdata(q_sdata), .s_tstrb(q_sstrb),
    .s_tkeep(q_skeep), .s_tlast(q_slast), .s_tuser(q_suser),
    .m_tvalid(q_mvalid), .m_tready(q_mready), .m_tdata(q_mdata), .m_tstrb(q_mstrb),
    .m_tkeep(q_mkeep), .m_tlast(q_mlast), .m_tuser(q_muser),
    .fill_level(q_fill), .full(q_full), .empty(q_empty));

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    for (int k = 0; k < 3; k++) @(negedge clk);
    n_cmp++; if (c_fill !== 5'd0) begin n_err++; $display("FAIL rst_fill got=%0d exp=0", c_fill); end
    n_cmp++; if (c_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got=%b exp=1", c_empty); end
    n_cmp++; if (c_mvalid !== 1'b0) begin n_err++; $display("FAIL rst_mvalid got=%b exp=0", c_mvalid); end
    n_cmp++; if (c_sready !== 1'b0) begin n_err++; $display("FAIL rst_sready got=%b exp=0", c_sready); end
    n_cmp++; if (c_full !== 1'b0) begin n_err++; $display("FAIL rst_full got=%b exp=0", c_full); end
    areset = 1'b0;
    #1;
    n_cmp++; if (c_sready !== 1'b0) begin n_err++; $display("FAIL rel_sready_early got=%b exp=0", c_sready); end
    @(negedge clk);
    n_cmp++; if (c_sready !== 1'b1) begin n_err++; $display("FAIL rel_sready got=%b exp=1", c_sready); end
    // Five beats, then reset mid-stream.
    for (int i = 0; i < 5; i++) begin
      c_svalid = 1'b1; c_sdata = 32'(i); c_slast = 1'b0;
      @(negedge clk);
    end
    c_svalid = 1'b0;
    n_cmp++; if (c_fill !== 5'd5) begin n_err++; $display("FAIL pre_rst_fill got=%0d exp=5", c_fill); end
    n_cmp++; if (c_mvalid !== 1'b1) begin n_err++; $display("FAIL pre_rst_mvalid got=%b exp=1", c_mvalid); end
    areset = 1'b1;
    #1;
    n_cmp++; if (c_fill !== 5'd0) begin n_err++; $display("FAIL mid_rst_fill got=%0d exp=0", c_fill); end
    n_cmp++; if (c_empty !== 1'b1) begin n_err++; $display("FAIL mid_rst_empty got=%b exp=1", c_empty); end
    n_cmp++; if (c_mvalid !== 1'b0) begin n_err++; $display("FAIL mid_rst_mvalid got=%b exp=0", c_mvalid); end
    n_cmp++; if (c_sready !== 1'b0) begin n_err++; $display("FAIL mid_rst_sready got=%b exp=0", c_sready); end
    @(negedge clk); @(negedge clk);
    n_cmp++; if (c_sready !== 1'b0) begin n_err++; $display("FAIL hold_rst_sready got=%b exp=0", c_sready); end
    n_cmp++; if (c_fill !== 5'd0) begin n_err++; $display("FAIL hold_rst_fill got=%0d exp=0", c_fill); end
    areset = 1'b0;
    @(negedge clk);
    n_cmp++; if (c_sready !== 1'b1) begin n_err++; $display("FAIL rel2_sready got=%b exp=1", c_sready); end
    n_cmp++; if (c_empty !== 1'b1) begin n_err++; $display("FAIL rel2_empty got=%b exp=1", c_empty); end
  endtask

  task automatic test_fill();
    logic [3:0] nib;
    c_mready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nib = 4'(i);
      c_svalid = 1'b1; c_sdata = 32'(i); c_sstrb = nib; c_skeep = ~nib;
      c_suser = 32'hA500_0000 | 32'(i); c_slast = (nib[1:0] == 2'b11);
      @(negedge clk);
    end
    n_cmp++; if (c_full !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b exp=1", c_full); end
    n_cmp++; if (c_sready !== 1'b0) begin n_err++; $display("FAIL fill_sready got=%b exp=0", c_sready); end
    n_cmp++; if (c_fill !== 5'd16) begin n_err++; $display("FAIL fill_level got=%0d exp=16", c_fill); end
    c_sdata = 32'hDEAD_BEEF;
    @(negedge clk);
    c_svalid = 1'b0;
    n_cmp++; if (c_fill !== 5'd16) begin n_err++; $display("FAIL full_nowrite got=%0d exp=16", c_fill); end
    c_mready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nib = 4'(i);
      n_cmp++; if (c_mvalid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, c_mvalid); end
      n_cmp++; if (c_mdata !== 32'(i)) begin n_err++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, c_mdata, 32'(i)); end
      n_cmp++; if (c_mstrb !== nib) begin n_err++; $display("FAIL drain_strb[%0d] got=%h exp=%h", i, c_mstrb, nib); end
      n_cmp++; if (c_mkeep !== ~nib) begin n_err++; $display("FAIL drain_keep[%0d] got=%h exp=%h", i, c_mkeep, ~nib); end
      n_cmp++; if (c_muser !== (32'hA500_0000 | 32'(i))) begin n_err++; $display("FAIL drain_user[%0d] got=%h", i, c_muser); end
      n_cmp++; if (c_mlast !== (nib[1:0] == 2'b11)) begin n_err++; $display("FAIL drain_last[%0d] got=%b", i, c_mlast); end
      if (i == 1) begin
        n_cmp++; if (c_sready !== 1'b1) begin n_err++; $display("FAIL drain_sready got=%b exp=1", c_sready); end
      end
      @(negedge clk);
    end
    c_mready = 1'b0;
    n_cmp++; if (c_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%b exp=1", c_empty); end
  endtask

  task automatic test_stream();
    c_mready = 1'b1; c_slast = 1'b0; c_sstrb = 4'hF; c_skeep = 4'hF; c_suser = '0;
    for (int t = 0; t <= 100; t++) begin
      if (t == 0) begin
        n_cmp++; if (c_mvalid !== 1'b0) begin n_err++; $display("FAIL stream_idle got=%b exp=0", c_mvalid); end
      end else begin
        n_cmp++; if (c_mvalid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got=%b exp=1", t, c_mvalid); end
        n_cmp++; if (c_mdata !== 32'h100 + 32'(t - 1)) begin n_err++; $display("FAIL stream_data[%0d] got=%h exp=%h", t, c_mdata, 32'h100 + 32'(t - 1)); end
        n_cmp++; if (c_fill !== 5'd1) begin n_err++; $display("FAIL stream_fill[%0d] got=%0d exp=1", t, c_fill); end
      end
      c_svalid = (t < 100);
      c_sdata  = 32'h100 + 32'(t);
      @(negedge clk);
    end
    c_svalid = 1'b0; c_mready = 1'b0;
    n_cmp++; if (c_empty !== 1'b1) begin n_err++; $display("FAIL stream_empty got=%b exp=1", c_empty); end
  endtask

  task automatic test_pkt();
    p_mready = 1'b1; p_sstrb = 4'hF; p_skeep = 4'hF; p_suser = 32'h55;
    for (int i = 0; i < 4; i++) begin
      p_svalid = 1'b1; p_sdata = 32'h40 + 32'(i); p_slast = (i == 3);
      @(negedge clk);
      p_svalid = 1'b0; p_slast = 1'b0;
      if (i < 3) begin
        n_cmp++; if (p_mvalid !== 1'b0) begin n_err++; $display("FAIL pkt_hold[%0d] got=%b exp=0", i, p_mvalid); end
        @(negedge clk);
        n_cmp++; if (p_mvalid !== 1'b0) begin n_err++; $display("FAIL pkt_idle[%0d] got=%b exp=0", i, p_mvalid); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (p_mvalid !== 1'b1) begin n_err++; $display("FAIL pkt_valid[%0d] got=%b exp=1", i, p_mvalid); end
      n_cmp++; if (p_mdata !== 32'h40 + 32'(i)) begin n_err++; $display("FAIL pkt_data[%0d] got=%h exp=%h", i, p_mdata, 32'h40 + 32'(i)); end
      n_cmp++; if (p_mlast !== (i == 3)) begin n_err++; $display("FAIL pkt_last[%0d] got=%b", i, p_mlast); end
      @(negedge clk);
    end
    n_cmp++; if (p_mvalid !== 1'b0) begin n_err++; $display("FAIL pkt_after got=%b exp=0", p_mvalid); end
    n_cmp++; if (p_empty !== 1'b1) begin n_err++; $display("FAIL pkt_empty got=%b exp=1", p_empty); end
    p_mready = 1'b0;
  endtask

  task automatic test_flush();
    int  wr_idx = 1;
    int  rd_idx = 1;
    bit  seen_full = 0;
    bit  chk_set = 0;
    bit  chk_clr = 0;
    bit  w, r;
    q_mready = 1'b1; q_sstrb = 4'hF; q_skeep = 4'hF; q_suser = '0;
    for (int cyc = 0; cyc < 200 && rd_idx <= 12; cyc++) begin
      q_svalid = (wr_idx <= 12);
      q_sdata  = 32'(wr_idx);
      q_slast  = (wr_idx == 12);
      w = q_svalid && q_sready;
      r = q_mvalid && q_mready;
      if (chk_set) begin
        chk_set = 0;
        n_cmp++; if (q_mvalid !== 1'b1) begin n_err++; $display("FAIL flush_valid got=%b exp=1", q_mvalid); end
        n_cmp++; if (u_q.flush !== 1'b1) begin n_err++; $display("FAIL flush_set got=%b exp=1", u_q.flush); end
      end
      if (chk_clr) begin
        chk_clr = 0;
        n_cmp++; if (u_q.flush !== 1'b0) begin n_err++; $display("FAIL flush_clear got=%b exp=0", u_q.flush); end
      end
      if (!seen_full) begin
        n_cmp++; if (q_mvalid !== 1'b0) begin n_err++; $display("FAIL flush_early[%0d] got=%b exp=0", cyc, q_mvalid); end
        if (q_full === 1'b1) begin
          seen_full = 1; chk_set = 1;
          n_cmp++; if (q_fill !== 4'd8) begin n_err++; $display("FAIL flush_fill got=%0d exp=8", q_fill); end
        end
      end
      if (r) begin
        n_cmp++; if (q_mdata !== 32'(rd_idx)) begin n_err++; $display("FAIL flush_data[%0d] got=%h exp=%h", rd_idx, q_mdata, 32'(rd_idx)); end
        n_cmp++; if (q_mlast !== (rd_idx == 12)) begin n_err++; $display("FAIL flush_last[%0d] got=%b", rd_idx, q_mlast); end
        if (rd_idx == 12) chk_clr = 1;
      end
      @(negedge clk);
      if (w) wr_idx++;
      if (r) rd_idx++;
    end
    q_svalid = 1'b0;
    n_cmp++; if (rd_idx !== 13) begin n_err++; $display("FAIL flush_count got=%0d exp=13", rd_idx); end
    n_cmp++; if (u_q.flush !== 1'b0) begin n_err++; $display("FAIL flush_final got=%b exp=0", u_q.flush); end
    n_cmp++; if (q_empty !== 1'b1) begin n_err++; $display("FAIL flush_empty got=%b exp=1", q_empty); end
    q_mready = 1'b0;
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [72:0] qc[$];
    logic [72:0] qp[$];
    logic [72:0] exp_v, cur_c, cur_p, hold_c, hold_p;
    int  wc = 0, wp = 0, rc = 0, rp = 0;
    bit  pend_c = 0, pend_p = 0, stall_c = 0, stall_p = 0;
    bit  wrc, wrp, rdc, rdp;
    int  cyc = 0;
    hold_c = '0; hold_p = '0;
    while ((rc < N || rp < N) && cyc < 60000) begin
      // Sources keep a beat asserted until it is accepted.
      if (!pend_c && wc < N && ($urandom_range(1) == 1)) begin
        c_sdata = $urandom; c_suser = $urandom; c_sstrb = 4'($urandom); c_skeep = 4'($urandom);
        c_slast = ($urandom_range(3) == 0) || (wc == N - 1);
        pend_c = 1;
      end
      if (!pend_p && wp < N && ($urandom_range(1) == 1)) begin
        p_sdata = $urandom; p_suser = $urandom; p_sstrb = 4'($urandom); p_skeep = 4'($urandom);
        p_slast = ($urandom_range(3) == 0) || (wp == N - 1);
        pend_p = 1;
      end
      c_svalid = pend_c; p_svalid = pend_p;
      c_mready = ($urandom_range(1) == 1);
      p_mready = ($urandom_range(1) == 1);
      wrc = c_svalid && c_sready; wrp = p_svalid && p_sready;
      rdc = c_mvalid && c_mready; rdp = p_mvalid && p_mready;
      cur_c = {c_mdata, c_mstrb, c_mkeep, c_mlast, c_muser};
      cur_p = {p_mdata, p_mstrb, p_mkeep, p_mlast, p_muser};
      if (stall_c) begin
        n_cmp++; if (c_mvalid !== 1'b1 || cur_c !== hold_c) begin n_err++; $display("FAIL rnd_stable_c cyc=%0d valid=%b got=%h exp=%h", cyc, c_mvalid, cur_c, hold_c); end
      end
      if (stall_p) begin
        n_cmp++; if (p_mvalid !== 1'b1 || cur_p !== hold_p) begin n_err++; $display("FAIL rnd_stable_p cyc=%0d valid=%b got=%h exp=%h", cyc, p_mvalid, cur_p, hold_p); end
      end
      if (rdc) begin
        n_cmp++;
        if (qc.size() == 0) begin n_err++; $display("FAIL rnd_c unexpected beat got=%h exp=none", cur_c); end
        else begin
          exp_v = qc.pop_front();
          if (cur_c !== exp_v) begin n_err++; $display("FAIL rnd_c beat=%0d got=%h exp=%h", rc, cur_c, exp_v); end
        end
        rc++;
      end
      if (rdp) begin
        n_cmp++;
        if (qp.size() == 0) begin n_err++; $display("FAIL rnd_p unexpected beat got=%h exp=none", cur_p); end
        else begin
          exp_v = qp.pop_front();
          if (cur_p !== exp_v) begin n_err++; $display("FAIL rnd_p beat=%0d got=%h exp=%h", rp, cur_p, exp_v); end
        end
        rp++;
      end
      if (wrc) begin qc.push_back({c_sdata, c_sstrb, c_skeep, c_slast, c_suser}); wc++; pend_c = 0; end
      if (wrp) begin qp.push_back({p_sdata, p_sstrb, p_skeep, p_slast, p_suser}); wp++; pend_p = 0; end
      stall_c = c_mvalid && !c_mready; hold_c = cur_c;
      stall_p = p_mvalid && !p_mready; hold_p = cur_p;
      @(negedge clk);
      cyc++;
    end
    c_svalid = 1'b0; p_svalid = 1'b0; c_mready = 1'b0; p_mready = 1'b0;
    n_cmp++; if (rc !== N) begin n_err++; $display("FAIL rnd_c_count got=%0d exp=%0d", rc, N); end
    n_cmp++; if (rp !== N) begin n_err++; $display("FAIL rnd_p_count got=%0d exp=%0d", rp, N); end
    n_cmp++; if (c_empty !== 1'b1) begin n_err++; $display("FAIL rnd_c_empty got=%b exp=1", c_empty); end
    n_cmp++; if (p_empty !== 1'b1) begin n_err++; $display("FAIL rnd_p_empty got=%b exp=1", p_empty); end
  endtask

  initial begin
    areset = 1'b1;
    c_svalid = 0; c_sdata = '0; c_sstrb = '0; c_skeep = '0; c_slast = 0; c_suser = '0; c_mready = 0;
    p_svalid = 0; p_sdata = '0; p_sstrb = '0; p_skeep = '0; p_slast = 0; p_suser = '0; p_mready = 0;
    q_svalid = 0; q_sdata = '0; q_sstrb = '0; q_skeep = '0; q_slast = 0; q_suser = '0; q_mready = 0;
    test_reset();
    test_fill();
    test_stream();
    test_pkt();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
